// File: rtl/countdown_pkg.sv
// Shared types, defaults and the round-robin pick helper for the countdown scheduler.
package countdown_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefWidth = 8;
  localparam int unsigned MaxReq   = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // One-hot winner: first set bit of req scanning ptr, ptr+1, ... modulo nreq.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input logic [2:0]        ptr,
                                                input logic [3:0]        nreq);
    logic [MaxReq-1:0] onehot;
    logic              found;
    logic [3:0]        idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MaxReq; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= nreq) idx = idx - nreq;
      if ((4'(k) < nreq) && !found && req[idx[2:0]]) begin
        onehot[idx[2:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/down_cntr.sv
// Loadable down counter that saturates at zero; load wins over enable.
module down_cntr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Counter register: load, otherwise decrement down to the zero floor.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sched.sv
// Round-robin scheduler sharing one down counter among NREQ timer requesters.
module countdown_sched
  import countdown_pkg::*;
#(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  abort,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_q;
  logic [PW-1:0]     next_ptr;
  logic [MaxReq-1:0] req_ext;
  logic [MaxReq-1:0] winner_full;
  logic [NREQ-1:0]   winner_oh;
  logic [PW-1:0]     winner_idx;
  logic [WIDTH-1:0]  load_sel;
  logic              cnt_load;
  logic [WIDTH-1:0]  cnt_load_val;
  logic              cnt_en;
  logic              cnt_zero;
  logic              unused_pick;

  // Widen req to the helper's fixed width.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

  assign winner_full = rr_pick(req_ext, 3'(ptr_q), 4'(NREQ));
  assign winner_oh   = winner_full[NREQ-1:0];
  assign unused_pick = ^winner_full;

  // Convert the one-hot winner to an index for the load_val mux and pointer update.
  always_comb begin
    winner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner_oh[i]) winner_idx = PW'(i);
    end
  end

  assign load_sel = load_val[winner_idx*WIDTH +: WIDTH];
  assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // Counter controls: load the winner's length on grant, clear on abort, count in RUN.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    if (state_q == StIdle && |req) begin
      cnt_load     = 1'b1;
      cnt_load_val = load_sel;
    end else if (state_q == StRun) begin
      cnt_load = abort;
      cnt_en   = 1'b1;
    end
  end

  down_cntr #(
    .WIDTH (WIDTH)
  ) u_down_cntr (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (count),
    .zero     (cnt_zero)
  );

  // Scheduler FSM with registered grant, busy and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= '0;
          if (|req) begin
            grant   <= winner_oh;
            owner_q <= winner_idx;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Abort takes precedence over reaching zero in the same cycle.
          if (abort) begin
            grant   <= '0;
            busy    <= 1'b0;
            ptr_q   <= next_ptr;
            state_q <= StIdle;
          end else if (cnt_zero) begin
            done    <= grant;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= '0;
          grant   <= '0;
          busy    <= 1'b0;
          ptr_q   <= next_ptr;
          state_q <= StIdle;
        end
        default: begin
          done    <= '0;
          grant   <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_sched.sv
// Self-checking bench for countdown_sched: directed scenarios plus randomized traffic.
module tb_countdown_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] load_val;
  logic                  abort;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int vectors    = 0;
  int miscompares = 0;

  // Job-level reference: owner (-1 when idle), job length, cycles since grant, pointer.
  int m_owner = -1;
  int m_len   = 0;
  int m_age   = 0;
  int m_ptr   = 0;
  logic [NREQ-1:0]  m_grant;
  logic             m_busy;
  logic [WIDTH-1:0] m_count;
  logic [NREQ-1:0]  m_done;

  countdown_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .load_val (load_val),
    .abort    (abort),
    .grant    (grant),
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Advance the reference by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_len   = int'(load_val[m_owner*WIDTH +: WIDTH]);
          m_age   = 1;
        end
      end
    end else if ((m_age <= m_len + 1 && abort) || m_age == m_len + 2) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_owner = -1;
    end else begin
      m_age++;
    end
    if (m_owner < 0) begin
      m_grant = '0;
      m_busy  = 1'b0;
      m_count = '0;
      m_done  = '0;
    end else begin
      m_grant = NREQ'(1 << m_owner);
      m_busy  = 1'b1;
      m_count = (m_age <= m_len) ? WIDTH'(m_len - m_age + 1) : '0;
      m_done  = (m_age == m_len + 2) ? m_grant : '0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req      = '0;
    abort    = 1'b0;
    load_val = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    req      = 4'b1111;
    abort    = 1'b0;
    load_val = {4{8'd3}};
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if ({grant, busy, count, done} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: grant=%b busy=%b count=%0d done=%b, required all zero",
                 grant, busy, count, done);
      end
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL reset_first_grant: grant=%b required 0001", grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    load_val[0 +: 8] = 8'd5;
    tick();
    vectors++;
    if (grant !== 4'b0001 || count !== 8'd5) begin
      miscompares++;
      $display("FAIL single_c1: grant=%b count=%0d required 0001/5", grant, count);
    end
    req = '0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (c == 6) begin
        vectors++;
        if (count !== 8'd0) begin
          miscompares++;
          $display("FAIL single_count_c6: count=%0d required 0", count);
        end
      end
      vectors++;
      if (done !== ((c == 7) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL single_done_c%0d: done=%b required %b", c, done,
                 (c == 7) ? 4'b0001 : 4'b0000);
      end
      if (c == 8) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL single_busy_c8: busy=%b required 0", busy);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    req = 4'b0100;
    load_val[16 +: 8] = 8'd0;
    tick();
    vectors++;
    if (grant !== 4'b0100 || count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_c1: grant=%b count=%0d required 0100/0", grant, count);
    end
    req = '0;
    tick();
    vectors++;
    if (done !== 4'b0100) begin
      miscompares++;
      $display("FAIL zero_done_c2: done=%b required 0100", done);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;
    do_reset();
    req      = 4'b1111;
    load_val = {4{8'd2}};
    for (int t = 1; t <= 25; t++) begin
      tick();
      eg = (((t - 1) % 5) < 4) ? NREQ'(1 << (((t - 1) / 5) % NREQ)) : '0;
      ed = (((t - 1) % 5) == 3) ? eg : '0;
      vectors++;
      if (grant !== eg || done !== ed) begin
        miscompares++;
        $display("FAIL contention_t%0d: grant=%b done=%b required %b/%b", t, grant, done, eg, ed);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0010;
    load_val[8 +: 8] = 8'd10;
    tick();
    for (int c = 2; c <= 8; c++) tick();
    vectors++;
    if (count !== 8'd3) begin
      miscompares++;
      $display("FAIL abort_pre_count: count=%0d required 3", count);
    end
    abort = 1'b1;
    req   = 4'b0110;
    load_val[16 +: 8] = 8'd4;
    tick();
    vectors++;
    if (grant !== 4'b0000 || count !== 8'd0 || done !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: grant=%b count=%0d done=%b busy=%b required 0/0/0/0",
               grant, count, done, busy);
    end
    abort = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0100 || count !== 8'd4) begin
      miscompares++;
      $display("FAIL abort_next_winner: grant=%b count=%0d required 0100/4", grant, count);
    end
  endtask

  task automatic test_abort_at_zero();
    do_reset();
    req = 4'b0001;
    load_val[0 +: 8] = 8'd1;
    tick();
    req = '0;
    tick();
    vectors++;
    if (count !== 8'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort0_pre: count=%0d busy=%b required 0/1", count, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (done !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort0_idle: done=%b grant=%b busy=%b required 0/0/0", done, grant, busy);
    end
    tick();
    vectors++;
    if (done !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort0_no_late_done: done=%b required 0000", done);
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    req = 4'b1000;
    load_val[24 +: 8] = 8'd6;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = '0;
    vectors++;
    if ({grant, busy, count, done} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: grant=%b busy=%b count=%0d done=%b required all zero",
               grant, busy, count, done);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      req   = NREQ'($urandom_range(0, 15));
      abort = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) load_val[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 6));
      tick();
      vectors++;
      if (grant !== m_grant || busy !== m_busy || count !== m_count || done !== m_done) begin
        miscompares++;
        $display("FAIL random_%0d: grant=%b busy=%b count=%0d done=%b required %b/%b/%0d/%b",
                 n, grant, busy, count, done, m_grant, m_busy, m_count, m_done);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    load_val = '0;
    abort    = 1'b0;
    test_reset();
    test_single();
    test_zero_len();
    test_contention();
    test_abort();
    test_abort_at_zero();
    test_reset_mid_job();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
